// File: rtl/interrupt_ctrl.sv
// ============================================================================
// Module   : interrupt_ctrl
// Purpose  : Five-source IF/IE interrupt controller with fixed priority and
//            vector output. Define INTC_EDGE_DETECT_EN for level inputs with
//            rising-edge detection; default build treats irq_src as ce pulses.
// Revision : 1.0
// ============================================================================
`default_nettype none

module interrupt_ctrl #(
  parameter logic [7:0] VEC_BASE = 8'h40
) (
  input  logic       clk_sys,
  input  logic       reset_n,
  input  logic       ce,
  input  logic [4:0] irq_src,
  input  logic       cpu_sel_if,
  input  logic       cpu_sel_ie,
  input  logic       cpu_wr,
  input  logic [7:0] cpu_di,
  output logic [7:0] cpu_do,
  input  logic       irq_ack,
  output logic       irq_req,
  output logic [7:0] irq_vec,
  output logic       wake
);

  logic [4:0] if_q, if_d;
  logic [7:0] ie_q, ie_d;
  logic       req_q, req_d;
  logic [7:0] vec_q, vec_d;

  logic       wr_if, wr_ie, ack_ok;
  logic [4:0] evt, ack_sel, ack_clr, wr_set, pend;

  assign wr_if  = ce & cpu_wr & cpu_sel_if;
  assign wr_ie  = ce & cpu_wr & cpu_sel_ie;
  assign ack_ok = ce & irq_ack & req_q;

  // Decode the registered vector back into the IF bit it stands for.
  for (genvar n = 0; n < 5; n++) begin : g_ack_sel
    assign ack_sel[n] = (vec_q == VEC_BASE + 8'(8 * n));
  end

  assign ack_clr = ack_ok ? ack_sel : 5'h00;
  assign wr_set  = wr_if ? cpu_di[4:0] : 5'h00;

  // The bit being acknowledged is hidden from the next presentation unless
  // it is requested again in the same cycle, so a serviced vector never repeats.
  assign pend = if_q & ie_q[4:0] & ~(ack_clr & ~evt & ~wr_set);

`ifdef INTC_EDGE_DETECT_EN
  logic [4:0] hist_q;
  logic [4:0] held_q, held_d;
  logic       armed_q;
  logic [4:0] rise;

  // History is only trusted after one post-reset sample, so sources already
  // high at release are not mistaken for edges.
  assign rise   = armed_q ? (irq_src & ~hist_q) : 5'h00;
  assign evt    = ce ? (held_q | rise) : 5'h00;
  assign held_d = ce ? 5'h00 : (held_q | rise);

  always_ff @(posedge clk_sys or negedge reset_n) begin
    if (!reset_n) begin
      hist_q  <= 5'h00;
      held_q  <= 5'h00;
      armed_q <= 1'b0;
    end else begin
      hist_q  <= irq_src;
      held_q  <= held_d;
      armed_q <= 1'b1;
    end
  end
`else
  assign evt = ce ? irq_src : 5'h00;
`endif

  always_comb begin
    if_d  = if_q;
    ie_d  = ie_q;
    req_d = req_q;
    vec_d = vec_q;
    if (ce) begin
      if_d = if_d & ~ack_clr;
      if (wr_if) if_d = cpu_di[4:0];
      if_d = if_d | evt;
      if (wr_ie) ie_d = cpu_di;
      req_d = |pend;
      vec_d = 8'h00;
      for (int n = 4; n >= 0; n--) begin
        if (pend[n]) vec_d = VEC_BASE + 8'(8 * n);
      end
    end
  end

  always_ff @(posedge clk_sys or negedge reset_n) begin
    if (!reset_n) begin
      if_q  <= 5'h00;
      ie_q  <= 8'h00;
      req_q <= 1'b0;
      vec_q <= 8'h00;
    end else begin
      if_q  <= if_d;
      ie_q  <= ie_d;
      req_q <= req_d;
      vec_q <= vec_d;
    end
  end

  assign cpu_do  = cpu_sel_if ? {3'b111, if_q} : ie_q;
  assign irq_req = req_q;
  assign irq_vec = vec_q;
  assign wake    = |(if_q & ie_q[4:0]);

endmodule

`default_nettype wire

// File: tb/tb_interrupt_ctrl.sv
// ============================================================================
// Module   : tb_interrupt_ctrl
// Purpose  : Directed self-checking bench for interrupt_ctrl (either build).
// Revision : 1.0
// ============================================================================
`default_nettype none

module tb_interrupt_ctrl;

  logic       clk_sys = 1'b0;
  logic       reset_n = 1'b0;
  logic       ce = 1'b1;
  logic [4:0] irq_src = 5'h00;
  logic       cpu_sel_if = 1'b0;
  logic       cpu_sel_ie = 1'b0;
  logic       cpu_wr = 1'b0;
  logic [7:0] cpu_di = 8'h00;
  logic [7:0] cpu_do;
  logic       irq_ack = 1'b0;
  logic       irq_req;
  logic [7:0] irq_vec;
  logic       wake;

  int n_checks = 0;
  int n_errors = 0;

  interrupt_ctrl #(.VEC_BASE(8'h40)) dut (
    .clk_sys    (clk_sys),
    .reset_n    (reset_n),
    .ce         (ce),
    .irq_src    (irq_src),
    .cpu_sel_if (cpu_sel_if),
    .cpu_sel_ie (cpu_sel_ie),
    .cpu_wr     (cpu_wr),
    .cpu_di     (cpu_di),
    .cpu_do     (cpu_do),
    .irq_ack    (irq_ack),
    .irq_req    (irq_req),
    .irq_vec    (irq_vec),
    .wake       (wake)
  );

  always #5 clk_sys = ~clk_sys;

  task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk_sys);
    #1;
  endtask

  task automatic write_if(input logic [7:0] d);
    cpu_sel_if = 1'b1; cpu_wr = 1'b1; cpu_di = d;
    step();
    cpu_sel_if = 1'b0; cpu_wr = 1'b0;
  endtask

  task automatic write_ie(input logic [7:0] d);
    cpu_sel_ie = 1'b1; cpu_wr = 1'b1; cpu_di = d;
    step();
    cpu_sel_ie = 1'b0; cpu_wr = 1'b0;
  endtask

  task automatic check_if(input string tag, input logic [7:0] exp);
    cpu_sel_if = 1'b1;
    #1;
    check(tag, cpu_do, exp);
    cpu_sel_if = 1'b0;
  endtask

  task automatic check_ie(input string tag, input logic [7:0] exp);
    cpu_sel_if = 1'b0;
    #1;
    check(tag, cpu_do, exp);
  endtask

  task automatic check_out(input string tag, input logic req, input logic [7:0] vec);
    check({tag, "_req"}, {7'h00, irq_req}, {7'h00, req});
    check({tag, "_vec"}, irq_vec, vec);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    // Reset state
    #12;
    check_out("rst", 1'b0, 8'h00);
    check("rst_wake", {7'h00, wake}, 8'h00);
    check_if("rst_if", 8'hE0);
    check_ie("rst_ie", 8'h00);
    @(negedge clk_sys);
    reset_n = 1'b1;
    step();

    // Timer pulse with only timer enabled
    write_ie(8'h04);
    irq_src = 5'h04; step(); irq_src = 5'h00;
    check_if("tmr_if", 8'hE4);
    check_out("tmr_lat", 1'b0, 8'h00);
    step();
    check_out("tmr", 1'b1, 8'h50);
    check("tmr_wake", {7'h00, wake}, 8'h01);
    irq_ack = 1'b1; step(); irq_ack = 1'b0;
    check_if("tmr_ack_if", 8'hE0);
    check_out("tmr_ack", 1'b0, 8'h00);

    // Priority walk through two pending sources
    write_ie(8'h1F);
    write_if(8'h18);
    step();
    check_out("pri_a", 1'b1, 8'h58);
    irq_ack = 1'b1; step();
    check_if("pri_b_if", 8'hF0);
    check_out("pri_b", 1'b1, 8'h60);
    step(); irq_ack = 1'b0;
    check_if("pri_c_if", 8'hE0);
    check_out("pri_c", 1'b0, 8'h00);

    // Ack and new vblank pulse in the same cycle: source set wins
    write_if(8'h01);
    step();
    check_out("ackset_pre", 1'b1, 8'h40);
    irq_ack = 1'b1; irq_src = 5'h01; step(); irq_ack = 1'b0; irq_src = 5'h00;
    check_if("ackset_if", 8'hE1);
    check_out("ackset", 1'b1, 8'h40);

    // CPU IF write and serial pulse in the same cycle
    cpu_sel_if = 1'b1; cpu_wr = 1'b1; cpu_di = 8'h00; irq_src = 5'h08;
    step();
    cpu_sel_if = 1'b0; cpu_wr = 1'b0; irq_src = 5'h00;
    check_if("wrset_if", 8'hE8);
    step();
    check_out("wrset", 1'b1, 8'h58);

    // Joypad pending while masked, then enabled
    write_if(8'h00);
    write_ie(8'h00);
    step();
    irq_src = 5'h10; step(); irq_src = 5'h00;
    check_if("joy_if", 8'hF0);
    check_out("joy_masked", 1'b0, 8'h00);
    check("joy_wake0", {7'h00, wake}, 8'h00);
    write_ie(8'h10);
    check("joy_wake1", {7'h00, wake}, 8'h01);
    check_out("joy_lat", 1'b0, 8'h00);
    check_ie("joy_ie", 8'h10);
    step();
    check_out("joy", 1'b1, 8'h60);

    // Disable before ack: request drops, later ack ignored
    write_ie(8'h00);
    step();
    check_out("dis", 1'b0, 8'h00);
    irq_ack = 1'b1; step(); irq_ack = 1'b0;
    check_if("dis_ack_if", 8'hF0);

    // ce low freezes state; edge build holds the source edge for the next ce
    ce = 1'b0; irq_src = 5'h01;
    cpu_sel_if = 1'b1; cpu_wr = 1'b1; cpu_di = 8'h1F;
    step();
    cpu_sel_if = 1'b0; cpu_wr = 1'b0; irq_src = 5'h00;
    check_if("frz_if", 8'hF0);
    ce = 1'b1;
    step();
`ifdef INTC_EDGE_DETECT_EN
    check_if("frz_after_if", 8'hF1);
`else
    check_if("frz_after_if", 8'hF0);
`endif

    // Asynchronous reset mid-ack with everything pending and enabled
    write_if(8'h1F);
    write_ie(8'hFF);
    step();
    check_out("prerst", 1'b1, 8'h40);
    irq_ack = 1'b1;
    #1 reset_n = 1'b0;
    #1;
    check_out("arst", 1'b0, 8'h00);
    check("arst_wake", {7'h00, wake}, 8'h00);
    check_if("arst_if", 8'hE0);
    check_ie("arst_ie", 8'h00);
    irq_ack = 1'b0;
`ifdef INTC_EDGE_DETECT_EN
    irq_src = 5'h1F;
`endif
    @(negedge clk_sys);
    reset_n = 1'b1;
    step(); step(); step();
    check_if("rel_if", 8'hE0);
    irq_src = 5'h00;

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/interrupt_ctrl.md
INTERRUPT_CTRL -- requirements
Module: interrupt_ctrl

Interface
REQ-001 Parameter: VEC_BASE, 8'h40, vector of source 0; source n vector SHALL be VEC_BASE + 8*n.
REQ-002 clk_sys  in  1  system clock; all state SHALL change on posedge clk_sys only, apart from reset.
REQ-003 reset_n  in  1  reset; asynchronous, active-low.
REQ-004 ce  in  1  4 MHz CPU clock enable; state SHALL advance only when ce=1.
REQ-005 irq_src  in  5  request inputs: [0] vblank, [1] lcd stat, [2] timer, [3] serial, [4] joypad.
REQ-006 cpu_sel_if  in  1  CPU access targets IF (FF0F).
REQ-007 cpu_sel_ie  in  1  CPU access targets IE (FFFF).
REQ-008 cpu_wr  in  1  write strobe, qualified by ce and a select.
REQ-009 cpu_di  in  8  write data.
REQ-010 cpu_do  out  8  read data, combinational: IF selected -> {3'b111, IF[4:0]}; otherwise IE[7:0].
REQ-011 irq_ack  in  1  CPU services the interrupt presented on irq_vec, qualified by ce.
REQ-012 irq_req  out  1  registered; high while any (IF & IE[4:0]) bit is pending.
REQ-013 irq_vec  out  8  registered vector of the highest-priority pending source; 8'h00 when none.
REQ-014 wake  out  1  combinational OR of (IF & IE[4:0]); HALT exit regardless of CPU IME.

Function
REQ-015 IF[4:0] SHALL set bit n on a ce cycle when a source-n event occurs (detection per REQ-027/028).
REQ-016 Priority SHALL be fixed: bit 0 highest, bit 4 lowest.
REQ-017 On each ce, irq_req and irq_vec SHALL be registered from the current IF & IE[4:0], giving one-ce latency from IF/IE change to output.
REQ-018 IE write SHALL store all 8 bits; only IE[4:0] gates requests.
REQ-019 IF write SHALL store cpu_di[4:0]; cpu_di[7:5] ignored.
REQ-020 irq_ack with irq_req=1 SHALL clear the IF bit selected by the registered irq_vec in that ce cycle.
REQ-021 irq_ack with irq_req=0 SHALL be ignored.
REQ-022 Per-bit precedence within a ce cycle, lowest to highest: hold < ack clear < CPU IF write < source set.
REQ-023 A source event arriving while the same bit is already set SHALL be absorbed (no queueing).
REQ-024 After ack, irq_req/irq_vec SHALL reflect the next pending source one ce later; the serviced vector SHALL never be re-presented unless re-requested.
REQ-025 Changing IE to disable the presented source before ack SHALL drop irq_req on the next ce; a later ack SHALL be ignored.
REQ-026 ce=0 SHALL freeze all state; source edges occurring in non-ce cycles are covered by REQ-027.

Reset
REQ-029 reset_n=0 SHALL immediately force IF=5'h00, IE=8'h00, irq_req=0, irq_vec=8'h00, edge-detect history=5'h00.
REQ-030 Sources high at release SHALL NOT set IF until a new rising edge (edge mode) or a new pulse (pulse mode).
REQ-031 Reset asserted mid-ack SHALL leave no partial clear; post-reset state per REQ-029.

Configuration
REQ-032 Macro INTC_EDGE_DETECT_EN defined: irq_src are levels; a rising edge (current sample high, previous sample low, sampled every clk_sys) SHALL be latched as a pending event and applied to IF on the next ce.
REQ-033 INTC_EDGE_DETECT_EN undefined: irq_src are single-ce pulses (timer style); a bit is set when irq_src[n]=1 on a ce cycle; no history registers.
REQ-027 (edge mode) A rising edge in a non-ce cycle SHALL be held pending until the next ce, never lost.
REQ-028 (pulse mode) irq_src asserted without ce SHALL be ignored.

Verification
REQ-034 IE=8'h04, timer pulse -> IF=5'h04, cpu_do(IF)=8'hE4, one ce later irq_req=1, irq_vec=8'h50.
REQ-035 IE=8'h1F, IF write 5'h18 -> irq_vec=8'h58; ack -> IF=5'h10, irq_vec=8'h60; ack -> IF=0, irq_req=0, irq_vec=8'h00.
REQ-036 IF=5'h01 presented, ack and vblank pulse on the same ce -> IF[0] remains 1, irq_vec stays 8'h40.
REQ-037 IF write 8'h00 on the same ce as serial pulse -> IF=5'h08.
REQ-038 IE=8'h00, joypad pulse -> irq_req=0, wake=0; IE write 8'h10 -> wake=1 immediately, irq_req=1 one ce later; IE read=8'h10.
REQ-039 reset_n low mid-sequence with IF=5'h1F, IE=8'hFF -> all outputs and registers zero at once; edge build: irq_src held high across release -> IF stays 0.
